// File: rtl/ysyx_24080014_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_24080014_pkg;

    typedef enum logic [1:0] {
        S_ADDR,
        S_DATA,
        S_VALID,
        S_WAIT
    } ifu_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;

endpackage

// File: rtl/ysyx_24080014_if.sv
// AXI4-Lite read-address and read-data channels used by the fetch unit.
interface ysyx_24080014_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/ysyx_24080014_reg.sv
// Write-enabled register with synchronous reset to a parameterised value.
module ysyx_24080014_reg #(
    parameter int unsigned        WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ysyx_24080014_ifu.sv
// Instruction fetch unit: one outstanding AXI4-Lite read per retired instruction.
module ysyx_24080014_ifu
    import ysyx_24080014_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        pc_update,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_err,
    ysyx_24080014_if.master bus
);

    ifu_state_t  state;
    logic        misaligned;
    logic        pc_we;
    logic        inst_we;
    logic [31:0] inst_d;

    assign misaligned = (pc[1:0] != 2'b00);

    // Handshake outputs decode registered state only; rst gating keeps them low during reset.
    assign bus.arvalid = !rst && (state == S_ADDR) && !misaligned;
    assign bus.rready  = !rst && (state == S_DATA);
    assign inst_valid  = !rst && (state == S_VALID);
    assign bus.araddr  = pc;

    assign pc_we   = pc_update && (((state == S_VALID) && inst_ready) || (state == S_WAIT));
    assign inst_we = ((state == S_DATA) && bus.rvalid) || ((state == S_ADDR) && misaligned);
    assign inst_d  = (state == S_ADDR) ? '0 : bus.rdata;

    ysyx_24080014_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .we  (pc_we),
        .d   (next_pc),
        .q   (pc)
    );

    ysyx_24080014_reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_inst_reg (
        .clk (clk),
        .rst (rst),
        .we  (inst_we),
        .d   (inst_d),
        .q   (inst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_ADDR;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                S_ADDR: begin
                    // A misaligned PC never reaches the bus; report it as a faulted fetch.
                    if (misaligned) begin
                        state     <= S_VALID;
                        fetch_err <= 1'b1;
                    end else if (bus.arready) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.rvalid) begin
                        fetch_err <= (bus.rresp != RESP_OKAY);
                        state     <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (inst_ready) begin
                        state <= pc_update ? S_ADDR : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pc_update) begin
                        state <= S_ADDR;
                    end
                end
                default: state <= S_ADDR;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// Directed self-checking bench for the fetch unit with a hand-driven AXI slave.
module tb_ysyx_24080014_ifu;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        pc_update;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_err;

    int unsigned checks;
    int unsigned failures;

    ysyx_24080014_if bus ();

    ysyx_24080014_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .next_pc    (next_pc),
        .pc_update  (pc_update),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fetch_err  (fetch_err),
        .bus        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        next_pc      = '0;
        pc_update    = 1'b0;
        inst_ready   = 1'b0;
        bus.arready  = 1'b0;
        bus.rvalid   = 1'b0;
        bus.rdata    = '0;
        bus.rresp    = 2'b00;

        // Reset state
        tick();
        tick();
        check("rst_arvalid", {31'b0, bus.arvalid}, 32'd0);
        check("rst_rready", {31'b0, bus.rready}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst", inst, 32'h0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);

        // Zero-wait fetch: AR in cycle 0, R in cycle 1, inst_valid in cycle 2
        rst         = 1'b0;
        bus.arready = 1'b1;
        #1;
        check("c0_arvalid", {31'b0, bus.arvalid}, 32'd1);
        check("c0_araddr", bus.araddr, 32'h8000_0000);
        tick();
        check("c1_rready", {31'b0, bus.rready}, 32'd1);
        check("c1_arvalid", {31'b0, bus.arvalid}, 32'd0);
        check("c1_inst_valid", {31'b0, inst_valid}, 32'd0);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0000_0413;
        bus.rresp  = 2'b00;
        tick();
        bus.rvalid = 1'b0;
        bus.rdata  = 32'hFFFF_FFFF;
        check("c2_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("c2_inst", inst, 32'h0000_0413);
        check("c2_err", {31'b0, fetch_err}, 32'd0);

        // Decode stalls; a stray pc_update must not move pc
        for (int i = 0; i < 5; i++) begin
            pc_update = (i == 2);
            next_pc   = 32'h8000_0100;
            tick();
            check("stall_valid", {31'b0, inst_valid}, 32'd1);
            check("stall_inst", inst, 32'h0000_0413);
            check("stall_pc", pc, 32'h8000_0000);
        end
        pc_update = 1'b0;

        // Handshake together with pc_update skips S_WAIT
        inst_ready = 1'b1;
        pc_update  = 1'b1;
        next_pc    = 32'h8000_0010;
        tick();
        inst_ready = 1'b0;
        pc_update  = 1'b0;
        check("skip_arvalid", {31'b0, bus.arvalid}, 32'd1);
        check("skip_araddr", bus.araddr, 32'h8000_0010);
        check("skip_inst_valid", {31'b0, inst_valid}, 32'd0);

        // Error response
        tick();
        check("err_rready", {31'b0, bus.rready}, 32'd1);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hDEAD_BEEF;
        bus.rresp  = 2'b10;
        tick();
        bus.rvalid = 1'b0;
        bus.rresp  = 2'b00;
        check("err_valid", {31'b0, inst_valid}, 32'd1);
        check("err_flag", {31'b0, fetch_err}, 32'd1);
        check("err_inst", inst, 32'hDEAD_BEEF);

        // Plain handshake parks in S_WAIT
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("wait_valid", {31'b0, inst_valid}, 32'd0);
        check("wait_arvalid", {31'b0, bus.arvalid}, 32'd0);
        check("wait_pc", pc, 32'h8000_0010);

        // Misaligned target: no bus request, zero inst with error
        pc_update = 1'b1;
        next_pc   = 32'h8000_0006;
        tick();
        pc_update = 1'b0;
        check("mis_pc", pc, 32'h8000_0006);
        check("mis_arvalid", {31'b0, bus.arvalid}, 32'd0);
        tick();
        check("mis_valid", {31'b0, inst_valid}, 32'd1);
        check("mis_err", {31'b0, fetch_err}, 32'd1);
        check("mis_inst", inst, 32'h0);
        check("mis_arvalid2", {31'b0, bus.arvalid}, 32'd0);

        // Slow arready: request must hold steady
        inst_ready  = 1'b1;
        pc_update   = 1'b1;
        next_pc     = 32'h8000_0020;
        bus.arready = 1'b0;
        tick();
        inst_ready = 1'b0;
        pc_update  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hold_arvalid", {31'b0, bus.arvalid}, 32'd1);
            check("hold_araddr", bus.araddr, 32'h8000_0020);
            tick();
        end
        check("hold_arvalid_last", {31'b0, bus.arvalid}, 32'd1);
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        check("slow_rready", {31'b0, bus.rready}, 32'd1);

        // Reset mid-transaction abandons it
        rst = 1'b1;
        #1;
        check("rst_mid_rready", {31'b0, bus.rready}, 32'd0);
        tick();
        check("rst_mid_pc", pc, 32'h8000_0000);
        check("rst_mid_err", {31'b0, fetch_err}, 32'd0);
        check("rst_mid_valid", {31'b0, inst_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("refetch_arvalid", {31'b0, bus.arvalid}, 32'd1);
        check("refetch_araddr", bus.araddr, 32'h8000_0000);
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h0010_0073;
        tick();
        bus.rvalid = 1'b0;
        check("refetch_valid", {31'b0, inst_valid}, 32'd1);
        check("refetch_inst", inst, 32'h0010_0073);
        check("refetch_err", {31'b0, fetch_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
